clk_div_bank: RTL and testbench

// Multi-channel programmable clock divider. Generalises the fixed /2 and /4 clock generator.

---
 rtl/clk_div_bank.sv | 125 ++++++++++++
 tb/tb_clk_div_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of programmable 50%-duty clock dividers with glitch-free
//               per-channel stop, deferred half-period update and global resync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_bank #(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_half,
    input  logic                      resync,
    output logic [NUM_CH-1:0]         div_clk,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         cfg_pend
);

    localparam int               c_ch_w     = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // A zero half-period would never reach its terminal count.
    logic [CNT_W-1:0] w_half;
    assign w_half = (cfg_half == '0) ? c_one : cfg_half;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [c_ch_w-1:0] c_id = c_ch_w'(i);

        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_hp;
        logic [CNT_W-1:0] r_pend_val;
        logic             r_pend;
        logic             r_div;
        logic             r_tick;

        logic w_wr;
        logic w_active;
        logic w_toggle;
        logic w_div_nxt;
        logic w_apply;

        assign w_wr      = cfg_we && (cfg_ch == c_id);
        assign w_active  = (r_state != ST_IDLE);
        assign w_toggle  = w_active && (r_cnt == (r_hp - c_one));
        assign w_div_nxt = w_toggle ? ~r_div : r_div;
        // New ratio only takes effect at a clean low-phase start.
        assign w_apply   = r_pend && (resync || !w_active || (w_toggle && r_div));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_hp       <= c_def_half;
                r_pend_val <= c_def_half;
                r_pend     <= 1'b0;
                r_div      <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_hp <= r_pend_val;
                end
                if (w_wr) begin
                    r_pend_val <= w_half;
                    r_pend     <= 1'b1;
                end else if (w_apply) begin
                    r_pend <= 1'b0;
                end

                if (resync) begin
                    if (w_active) begin
                        r_div  <= 1'b0;
                        r_cnt  <= '0;
                        r_tick <= 1'b0;
                        if (r_state == ST_STOP) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_tick <= 1'b0;
                            if (en[i]) begin
                                r_state <= ST_RUN;
                                r_cnt   <= '0;
                            end
                        end
                        default: begin
                            r_div  <= w_div_nxt;
                            r_tick <= w_toggle && !r_div;
                            r_cnt  <= w_toggle ? '0 : (r_cnt + c_one);
                            // Disabled channels park only once the output is low.
                            if (en[i]) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state <= w_div_nxt ? ST_STOP : ST_IDLE;
                            end
                        end
                    endcase
                end
            end
        end

        assign div_clk[i]  = r_div;
        assign tick[i]     = r_tick;
        assign cfg_pend[i] = r_pend;
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Directed vector bench for clk_div_bank (3 channels, 8-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_bank;

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       resync;
    logic [2:0] div_clk;
    logic [2:0] tick;
    logic [2:0] cfg_pend;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] half;
        logic       rs;
        logic [2:0] div;
        logic [2:0] tck;
        logic [2:0] pend;
    } vec_t;

    vec_t vecs[$];

    clk_div_bank #(
        .NUM_CH  (3),
        .CNT_W   (8),
        .DEF_HALF(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_half(cfg_half),
        .resync  (resync),
        .div_clk (div_clk),
        .tick    (tick),
        .cfg_pend(cfg_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic v(input logic [2:0] e, input logic we, input logic [1:0] ch,
                     input logic [7:0] h, input logic rs, input logic [2:0] d,
                     input logic [2:0] t, input logic [2:0] p);
        vec_t x;
        x.en = e; x.we = we; x.ch = ch; x.half = h; x.rs = rs;
        x.div = d; x.tck = t; x.pend = p;
        vecs.push_back(x);
    endtask

    // Idle-input shorthand: only en changes.
    task automatic vi(input logic [2:0] e, input logic [2:0] d,
                      input logic [2:0] t, input logic [2:0] p);
        v(e, 1'b0, 2'd0, 8'd0, 1'b0, d, t, p);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step%0d: got %b want %b", name, idx, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; resync = 1'b0;

        // defaults, hp=1 on all channels
        vi(3'd7, 3'd0, 3'd0, 3'd0);
        vi(3'd7, 3'd7, 3'd7, 3'd0);
        vi(3'd7, 3'd0, 3'd0, 3'd0);
        vi(3'd7, 3'd7, 3'd7, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        // idle config: ch1=2, ch2=3, invalid channel ignored
        v(3'd0, 1'b1, 2'd1, 8'd2, 1'b0, 3'd0, 3'd0, 3'd2);
        v(3'd0, 1'b1, 2'd2, 8'd3, 1'b0, 3'd0, 3'd0, 3'd4);
        v(3'd0, 1'b1, 2'd3, 8'd5, 1'b0, 3'd0, 3'd0, 3'd0);
        vi(3'd7, 3'd0, 3'd0, 3'd0);
        vi(3'd7, 3'd1, 3'd1, 3'd0);
        vi(3'd7, 3'd2, 3'd2, 3'd0);
        vi(3'd7, 3'd7, 3'd5, 3'd0);
        vi(3'd7, 3'd4, 3'd0, 3'd0);
        vi(3'd7, 3'd5, 3'd1, 3'd0);
        vi(3'd7, 3'd2, 3'd2, 3'd0);
        vi(3'd7, 3'd3, 3'd1, 3'd0);
        vi(3'd7, 3'd0, 3'd0, 3'd0);
        vi(3'd7, 3'd5, 3'd5, 3'd0);
        vi(3'd0, 3'd6, 3'd2, 3'd0);
        vi(3'd0, 3'd6, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        // ch0 running hp=1, write 4 during high phase
        vi(3'd1, 3'd0, 3'd0, 3'd0);
        vi(3'd1, 3'd1, 3'd1, 3'd0);
        v(3'd1, 1'b1, 2'd0, 8'd4, 1'b0, 3'd0, 3'd0, 3'd1);
        vi(3'd1, 3'd1, 3'd1, 3'd1);
        vi(3'd1, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 3; k++) vi(3'd1, 3'd0, 3'd0, 3'd0);
        vi(3'd1, 3'd1, 3'd1, 3'd0);
        for (int k = 0; k < 3; k++) vi(3'd1, 3'd1, 3'd0, 3'd0);
        vi(3'd1, 3'd0, 3'd0, 3'd0);
        vi(3'd1, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        // ch1 hp=3, en dropped in high phase, then re-raised before the fall
        v(3'd0, 1'b1, 2'd1, 8'd3, 1'b0, 3'd0, 3'd0, 3'd2);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 3; k++) vi(3'd2, 3'd0, 3'd0, 3'd0);
        vi(3'd2, 3'd2, 3'd2, 3'd0);
        vi(3'd0, 3'd2, 3'd0, 3'd0);
        vi(3'd0, 3'd2, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 3; k++) vi(3'd2, 3'd0, 3'd0, 3'd0);
        vi(3'd2, 3'd2, 3'd2, 3'd0);
        vi(3'd0, 3'd2, 3'd0, 3'd0);
        vi(3'd2, 3'd2, 3'd0, 3'd0);
        for (int k = 0; k < 3; k++) vi(3'd2, 3'd0, 3'd0, 3'd0);
        vi(3'd2, 3'd2, 3'd2, 3'd0);
        vi(3'd0, 3'd2, 3'd0, 3'd0);
        vi(3'd0, 3'd2, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        // ch0 hp=2, ch1 hp=4, ch2 half=0 -> 1; resync tests
        v(3'd0, 1'b1, 2'd0, 8'd2, 1'b0, 3'd0, 3'd0, 3'd1);
        v(3'd0, 1'b1, 2'd1, 8'd4, 1'b0, 3'd0, 3'd0, 3'd2);
        v(3'd0, 1'b1, 2'd2, 8'd0, 1'b0, 3'd0, 3'd0, 3'd4);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        vi(3'd2, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd1, 3'd1, 3'd0);
        vi(3'd3, 3'd3, 3'd2, 3'd0);
        v(3'd3, 1'b1, 2'd0, 8'd2, 1'b0, 3'd2, 3'd0, 3'd1);
        v(3'd3, 1'b0, 2'd0, 8'd0, 1'b1, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd1, 3'd1, 3'd0);
        vi(3'd3, 3'd1, 3'd0, 3'd0);
        vi(3'd3, 3'd2, 3'd2, 3'd0);
        vi(3'd3, 3'd2, 3'd0, 3'd0);
        vi(3'd3, 3'd3, 3'd1, 3'd0);
        vi(3'd3, 3'd3, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        v(3'd3, 1'b0, 2'd0, 8'd0, 1'b1, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd0, 3'd0, 3'd0);
        vi(3'd3, 3'd1, 3'd1, 3'd0);
        vi(3'd0, 3'd1, 3'd0, 3'd0);
        v(3'd0, 1'b0, 2'd0, 8'd0, 1'b1, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        vi(3'd4, 3'd0, 3'd0, 3'd0);
        vi(3'd4, 3'd4, 3'd4, 3'd0);
        vi(3'd4, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd4, 3'd4, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        // write colliding with an apply edge; last value (5) ends up active
        v(3'd0, 1'b1, 2'd0, 8'd3, 1'b0, 3'd0, 3'd0, 3'd1);
        v(3'd0, 1'b1, 2'd0, 8'd5, 1'b0, 3'd0, 3'd0, 3'd1);
        vi(3'd0, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 5; k++) vi(3'd1, 3'd0, 3'd0, 3'd0);
        vi(3'd1, 3'd1, 3'd1, 3'd0);
        v(3'd0, 1'b0, 2'd0, 8'd0, 1'b1, 3'd0, 3'd0, 3'd0);
        vi(3'd0, 3'd0, 3'd0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_div", -1, div_clk, 3'd0);
        chk("rst_tick", -1, tick, 3'd0);
        chk("rst_pend", -1, cfg_pend, 3'd0);
        rst = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            en = vecs[n].en; cfg_we = vecs[n].we; cfg_ch = vecs[n].ch;
            cfg_half = vecs[n].half; resync = vecs[n].rs;
            @(posedge clk);
            #1;
            chk("div_clk", n, div_clk, vecs[n].div);
            chk("tick", n, tick, vecs[n].tck);
            chk("cfg_pend", n, cfg_pend, vecs[n].pend);
        end
        en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; resync = 1'b0;

        // asynchronous reset mid-period with ch0 hp=5 high and a pending write
        en = 3'd1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_pre_div", 0, div_clk, 3'd1);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd7;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        chk("arst_pre_pend", 0, cfg_pend, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_div", 0, div_clk, 3'd0);
        chk("arst_tick", 0, tick, 3'd0);
        chk("arst_pend", 0, cfg_pend, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_div", 0, div_clk, 3'd0);
        @(posedge clk);
        #1;
        chk("post_div", 1, div_clk, 3'd1);
        chk("post_tick", 1, tick, 3'd1);
        @(posedge clk);
        #1;
        chk("post_div", 2, div_clk, 3'd0);
        chk("post_pend", 2, cfg_pend, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
